// File: rtl/rsb_mp_pkg.sv
// rsb_mp_pkg: shared types and helpers for the multi-port counting register
// scoreboard (rsb_mp) and its sub-blocks.
package rsb_mp_pkg;

  typedef enum logic {
    RSB_RUN   = 1'b0,
    RSB_DRAIN = 1'b1
  } rsb_state_t;

  // Largest value a CNT_WIDTH-bit pending counter can hold.
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

  // Width of a writeback-port index (at least one bit).
  function automatic int sel_width(input int n_wb);
    return (n_wb > 1) ? $clog2(n_wb) : 1;
  endfunction

endpackage

// File: rtl/rsb_mp_if.sv
// rsb_mp_if: issue/writeback signal bundle of the register scoreboard.
//   master : issue stage / EXU side (drives flush, set, check and clear requests)
//   slave  : scoreboard side (returns ready, stall/forward info, status, errors)
interface rsb_mp_if
  import rsb_mp_pkg::*;
#(
  parameter int N_REG = 32,
  parameter int N_CHK = 2,
  parameter int N_WB  = 2
);
  localparam int AW = $clog2(N_REG);
  localparam int WW = sel_width(N_WB);

  logic                       pipe_flush;
  logic                       exu_idle;
  logic                       set_en;
  logic [AW-1:0]              set_rd_addr;
  logic                       set_ready;
  logic [N_CHK-1:0]           chk_en;
  logic [N_CHK-1:0][AW-1:0]   chk_addr;
  logic [N_CHK-1:0]           chk_stall;
  logic [N_CHK-1:0]           chk_fwd;
  logic [N_CHK-1:0][WW-1:0]   chk_fwd_sel;
  logic [N_WB-1:0]            clr_en;
  logic [N_WB-1:0][AW-1:0]    clr_addr;
  logic [N_REG-1:0]           busy_vec;
  logic                       draining;
  logic                       err_overflow;
  logic                       err_underflow;

  modport master (
    output pipe_flush, exu_idle, set_en, set_rd_addr, chk_en, chk_addr, clr_en, clr_addr,
    input  set_ready, chk_stall, chk_fwd, chk_fwd_sel, busy_vec, draining,
           err_overflow, err_underflow
  );

  modport slave (
    input  pipe_flush, exu_idle, set_en, set_rd_addr, chk_en, chk_addr, clr_en, clr_addr,
    output set_ready, chk_stall, chk_fwd, chk_fwd_sel, busy_vec, draining,
           err_overflow, err_underflow
  );

endinterface

// File: rtl/rsb_mp_clr_match.sv
// rsb_clr_match: combinational writeback matcher for one queried register.
//   addr     : queried register (0 never matches)
//   clr_en   : per-port writeback valid
//   clr_addr : per-port writeback rd
//   nclr     : number of valid writeback ports targeting addr
//   sel      : lowest-index matching port, 0 when nothing matches
module rsb_clr_match #(
  parameter int N_WB = 2,
  parameter int AW   = 5,
  parameter int WW   = 1,
  parameter int NW   = 2
) (
  input  logic [AW-1:0]           addr,
  input  logic [N_WB-1:0]         clr_en,
  input  logic [N_WB-1:0][AW-1:0] clr_addr,
  output logic [NW-1:0]           nclr,
  output logic [WW-1:0]           sel
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    nclr = '0;
    sel  = '0;
    // Walking downwards lets the lowest matching index win the select.
    for (int p = N_WB - 1; p >= 0; p--) begin
      if (clr_en[p] && clr_addr[p] == addr && addr != '0) begin
        nclr = nclr + NW'(1);
        sel  = WW'(p);
      end
    end
  end

endmodule

// File: rtl/rsb_mp.sv
// rsb_mp: multi-port counting register scoreboard for the issue stage.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : rsb_mp_if.slave -- set (issue of a tracked rd), N_CHK source
//              checks, N_WB writeback clears, flush/idle control, busy vector,
//              drain status and sticky overflow/underflow flags.
// Each register keeps a count of outstanding writes. After a flush the block
// drains (all counts forced to 0) until the EXU reports idle.
module rsb_mp
  import rsb_mp_pkg::*;
#(
  parameter int N_REG     = 32,
  parameter int N_CHK     = 2,
  parameter int N_WB      = 2,
  parameter int CNT_WIDTH = 2
) (
  input logic     clk,
  input logic     rst,
  rsb_mp_if.slave bus
);

  localparam int AW = $clog2(N_REG);
  localparam int WW = sel_width(N_WB);
  localparam int NW = $clog2(N_WB + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(cnt_max(CNT_WIDTH));

  rsb_state_t           state;
  logic [CNT_WIDTH-1:0] count    [N_REG];
  logic [CNT_WIDTH-1:0] rem      [N_REG];  // count after this cycle's clears
  logic [CNT_WIDTH-1:0] cnt_next [N_REG];
  logic [NW-1:0]        nclr     [N_REG];
  logic [WW-1:0]        unused_sel [N_REG];
  logic [N_REG-1:0]     under;
  logic [NW-1:0]        chk_nclr [N_CHK];
  logic [N_CHK-1:0][WW-1:0] chk_sel;
  logic                 run_upd;
  logic                 set_acc;

  // Counts only move in RUN cycles without a flush; otherwise they are zeroed.
  assign run_upd = (state == RSB_RUN) && !bus.pipe_flush;

  for (genvar r = 0; r < N_REG; r++) begin : g_reg_match
    rsb_clr_match #(.N_WB(N_WB), .AW(AW), .WW(WW), .NW(NW)) u_match (
      .addr     (AW'(r)),
      .clr_en   (bus.clr_en),
      .clr_addr (bus.clr_addr),
      .nclr     (nclr[r]),
      .sel      (unused_sel[r])
    );
  end

  for (genvar i = 0; i < N_CHK; i++) begin : g_chk_match
    rsb_clr_match #(.N_WB(N_WB), .AW(AW), .WW(WW), .NW(NW)) u_match (
      .addr     (bus.chk_addr[i]),
      .clr_en   (bus.clr_en),
      .clr_addr (bus.clr_addr),
      .nclr     (chk_nclr[i]),
      .sel      (chk_sel[i])
    );
  end

  // Saturating clear; a clear beyond the count is flagged as underflow.
  always_comb begin
    for (int r = 0; r < N_REG; r++) begin
      rem[r]   = '0;
      under[r] = 1'b0;
      if (int'(nclr[r]) > int'(count[r])) under[r] = 1'b1;
      else rem[r] = count[r] - CNT_WIDTH'(nclr[r]);
    end
  end

  assign bus.set_ready = (state == RSB_RUN) &&
                         (bus.set_rd_addr == '0 || rem[bus.set_rd_addr] != CNT_MAX);
  assign set_acc       = bus.set_en && bus.set_ready && bus.set_rd_addr != '0;

  always_comb begin
    for (int r = 0; r < N_REG; r++) begin
      cnt_next[r] = '0;
      if (run_upd)
        cnt_next[r] = rem[r] + CNT_WIDTH'(set_acc && bus.set_rd_addr == AW'(r));
    end
  end

  // Checks see committed counts minus same-cycle clears; a same-cycle set is
  // deliberately not bypassed.
  always_comb begin
    bus.chk_stall = '0;
    bus.chk_fwd   = '0;
    for (int i = 0; i < N_CHK; i++) begin
      if (bus.chk_en[i] && bus.chk_addr[i] != '0) begin
        bus.chk_stall[i] = (state == RSB_DRAIN) ||
                           (int'(count[bus.chk_addr[i]]) > int'(chk_nclr[i]));
        bus.chk_fwd[i]   = (chk_nclr[i] != '0);
      end
    end
  end

  assign bus.chk_fwd_sel = chk_sel;
  assign bus.draining    = (state == RSB_DRAIN);

  always_comb begin
    bus.busy_vec = '0;
    for (int r = 1; r < N_REG; r++) bus.busy_vec[r] = (count[r] != '0);
  end

  // NOTE: state, counters and flags use non-blocking assignments; the counter array is small flops, so it is reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N_REG; r++) count[r] <= '0;
    end else begin
      for (int r = 1; r < N_REG; r++) count[r] <= cnt_next[r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= RSB_RUN;
      bus.err_overflow  <= 1'b0;
      bus.err_underflow <= 1'b0;
    end else begin
      case (state)
        RSB_RUN:   if (bus.pipe_flush) state <= RSB_DRAIN;
        RSB_DRAIN: if (bus.exu_idle && !bus.pipe_flush) state <= RSB_RUN;
        default:   state <= RSB_RUN;
      endcase
      if (run_upd && bus.set_en && !bus.set_ready) bus.err_overflow  <= 1'b1;
      if (run_upd && |under)                       bus.err_underflow <= 1'b1;
    end
  end

endmodule
